// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity modes,
// receiver state encoding and a constant-foldable clog2 helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Smallest width able to hold 'value' distinct codes (0..value-1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Input conditioning for the UART receiver: a two-flop synchroniser on the
// raw line, plus capture of the samples just before and at mid-bit so a
// three-sample majority vote is available at sample_cnt = M+1.
module uart_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = clog2(OVERSAMPLE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             baud_tick,
  input  logic             uart_rx,
  input  logic [CNT_W-1:0] sample_cnt,
  output logic             rx_sync,
  output logic             bit_vote
);

  localparam int M = OVERSAMPLE / 2;

  logic sync_meta_reg;
  logic sync_reg;

  // Two-flop synchroniser; flops come up high so reset looks like an idle line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_reg <= 1'b1;
      sync_reg      <= 1'b1;
    end else begin
      sync_meta_reg <= uart_rx;
      sync_reg      <= sync_meta_reg;
    end
  end

  assign rx_sync = sync_reg;

  // The first two votes are stored at M-1 and M; the third is the live
  // synchronised sample on the deciding tick (M+1).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_capture
      logic sample_reg;

      // Capture one early vote sample at its fixed offset within the bit.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sample_reg <= 1'b1;
        end else if (baud_tick && (sample_cnt == CNT_W'(M - 1 + gi))) begin
          sample_reg <= sync_reg;
        end
      end
    end
  endgenerate

  assign bit_vote = (g_capture[0].sample_reg & g_capture[1].sample_reg) |
                    (g_capture[0].sample_reg & sync_reg) |
                    (g_capture[1].sample_reg & sync_reg);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled framing FSM, LSB-first shift
// register and a one-entry valid/ready holding register with parity,
// framing and sticky overrun reporting.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = clog2(OVERSAMPLE);
  localparam int IDX_W = clog2(DATA_BITS);
  localparam int M     = OVERSAMPLE / 2;

  localparam logic [CNT_W-1:0] VOTE_CNT = CNT_W'(M + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic             ODD_FLIP = (PARITY == PARITY_ODD);

  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic                 stop_idx_reg, stop_idx_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 perr_reg, perr_next;
  logic                 ferr_reg, ferr_next;
  logic                 commit;
  logic                 rx_sync;
  logic                 bit_vote;
  logic                 at_vote;
  logic                 at_end;

  uart_bit_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (CNT_W)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .baud_tick  (baud_tick),
    .uart_rx    (uart_rx),
    .sample_cnt (cnt_reg),
    .rx_sync    (rx_sync),
    .bit_vote   (bit_vote)
  );

  assign at_vote = (cnt_reg == VOTE_CNT);
  assign at_end  = (cnt_reg == LAST_CNT);
  assign busy    = (state_reg != ST_IDLE);

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      stop_idx_reg <= 1'b0;
      data_reg     <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      stop_idx_reg <= stop_idx_next;
      data_reg     <= data_next;
      perr_reg     <= perr_next;
      ferr_reg     <= ferr_next;
    end
  end

  // Next-state logic; everything advances only on baud ticks.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    stop_idx_next = stop_idx_reg;
    data_next     = data_reg;
    perr_next     = perr_reg;
    ferr_next     = ferr_reg;
    commit        = 1'b0;
    if (baud_tick) begin
      cnt_next = at_end ? '0 : cnt_reg + 1'b1;
      unique case (state_reg)
        ST_IDLE: begin
          cnt_next = '0;
          // Level-triggered start: any low sample begins a frame.
          if (!rx_sync) begin
            state_next    = ST_START;
            perr_next     = 1'b0;
            ferr_next     = 1'b0;
            stop_idx_next = 1'b0;
          end
        end
        ST_START: begin
          if (at_vote && bit_vote) begin
            // Glitch rather than a real start bit: drop silently.
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (at_end) begin
            state_next = ST_DATA;
            idx_next   = '0;
          end
        end
        ST_DATA: begin
          if (at_vote) begin
            data_next[idx_reg] = bit_vote;
          end
          if (at_end) begin
            if (idx_reg == LAST_IDX) begin
              state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (at_vote && (bit_vote != ((^data_reg) ^ ODD_FLIP))) begin
            perr_next = 1'b1;
          end
          if (at_end) begin
            state_next = ST_STOP;
          end
        end
        ST_STOP: begin
          if (at_vote && !bit_vote) begin
            ferr_next = 1'b1;
          end
          // The last stop bit ends at its decision point so a following
          // start bit can be caught early.
          if (at_vote && ((STOP_BITS == 1) || stop_idx_reg)) begin
            commit     = 1'b1;
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else if (at_end) begin
            stop_idx_next = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // One-entry holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (commit && (!rx_valid || rx_ready)) begin
        rx_data    <= data_reg;
        parity_err <= perr_reg;
        frame_err  <= ferr_next;
        rx_valid   <= 1'b1;
        overrun    <= 1'b0;
      end else if (commit) begin
        overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule
